// File: rtl/armleocpu_csr_requester.sv
// armleocpu_csr_requester: sequences Zicsr instructions into WRITE/READ/READ_WRITE
// commands, splitting set/clear forms into a READ followed by a WRITE.
module armleocpu_csr_requester #(
    parameter int CMD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_funct3,
    input  logic [11:0]          req_address,
    input  logic [4:0]           req_rs1_index,
    input  logic [31:0]          req_rs1_value,
    input  logic [4:0]           req_rd_index,
    output logic [CMD_WIDTH-1:0] csr_cmd,
    output logic [11:0]          csr_address,
    output logic [31:0]          csr_writedata,
    input  logic [31:0]          csr_readdata,
    input  logic                 csr_invalid,
    output logic                 resp_valid,
    output logic                 resp_illegal,
    output logic                 resp_rd_write,
    output logic [4:0]           resp_rd_index,
    output logic [31:0]          resp_rd_data
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RMW_WRITE = 2'd2, RESP = 2'd3;
    localparam logic [CMD_WIDTH-1:0] CMD_NONE = 0, CMD_WRITE = 1, CMD_READ = 2, CMD_READ_WRITE = 3;
    logic [1:0] state;
    logic [2:0] funct3;
    logic [11:0] address;
    logic [4:0] rd_index;
    logic [31:0] operand, old_value;
    logic mask_zero, illegal;
    logic is_rw;
    assign is_rw = funct3[1:0] == 2'b01;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            funct3 <= '0;
            address <= '0;
            rd_index <= '0;
            operand <= '0;
            old_value <= '0;
            mask_zero <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    funct3 <= req_funct3;
                    address <= req_address;
                    rd_index <= req_rd_index;
                    operand <= req_funct3[2] ? {27'd0, req_rs1_index} : req_rs1_value;
                    mask_zero <= req_rs1_index == 5'd0;
                    old_value <= '0;
                    illegal <= req_funct3[1:0] == 2'b00;
                    state <= req_funct3[1:0] == 2'b00 ? RESP : ISSUE;
                end
                ISSUE: begin
                    // A plain WRITE (rd == x0) returns nothing, so its readdata is not kept
                    if (csr_invalid) illegal <= 1'b1;
                    else if (!is_rw || rd_index != 5'd0) old_value <= csr_readdata;
                    state <= (csr_invalid || is_rw || mask_zero) ? RESP : RMW_WRITE;
                end
                RMW_WRITE: begin
                    if (csr_invalid) begin
                        illegal <= 1'b1;
                        old_value <= '0;
                    end
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        csr_cmd = state == ISSUE ? (is_rw ? (rd_index != 5'd0 ? CMD_READ_WRITE : CMD_WRITE) : CMD_READ)
                : state == RMW_WRITE ? CMD_WRITE : CMD_NONE;
        csr_writedata = (state == ISSUE && is_rw) ? operand
                      : state == RMW_WRITE ? (funct3[0] ? old_value & ~operand : old_value | operand)
                      : 32'd0;
    end
    assign req_ready = state == IDLE;
    assign csr_address = address;
    assign resp_valid = state == RESP;
    assign resp_illegal = illegal;
    assign resp_rd_index = rd_index;
    assign resp_rd_data = old_value;
    assign resp_rd_write = resp_valid && !illegal && rd_index != 5'd0;
endmodule

// File: tb/tb_armleocpu_csr_requester.sv
// tb_armleocpu_csr_requester: directed checks against a small CSR file model
// holding mscratch (0x340, RW) and mvendorid-like 0xF11 (read-only).
module tb_armleocpu_csr_requester;
    logic clk, rst, req_valid, req_ready, csr_invalid;
    logic resp_valid, resp_illegal, resp_rd_write;
    logic [2:0] req_funct3;
    logic [11:0] req_address, csr_address;
    logic [4:0] req_rs1_index, req_rd_index, resp_rd_index;
    logic [31:0] req_rs1_value, csr_writedata, csr_readdata, resp_rd_data;
    logic [3:0] csr_cmd;
    logic [31:0] mscratch;
    logic mem_clr;
    int tests = 0, fails = 0;

    armleocpu_csr_requester #(.CMD_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_address(req_address), .req_rs1_index(req_rs1_index),
        .req_rs1_value(req_rs1_value), .req_rd_index(req_rd_index), .csr_cmd(csr_cmd),
        .csr_address(csr_address), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .csr_invalid(csr_invalid), .resp_valid(resp_valid), .resp_illegal(resp_illegal),
        .resp_rd_write(resp_rd_write), .resp_rd_index(resp_rd_index), .resp_rd_data(resp_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        csr_readdata = csr_address == 12'h340 ? mscratch : csr_address == 12'hF11 ? 32'h0A1AA1E0 : 32'd0;
        csr_invalid = csr_cmd != 4'd0 && (csr_address == 12'hF11 ? (csr_cmd == 4'd1 || csr_cmd == 4'd3)
                                                                 : csr_address != 12'h340);
    end

    always @(posedge clk) begin
        if (mem_clr) mscratch <= 32'd0;
        else if ((csr_cmd == 4'd1 || csr_cmd == 4'd3) && !csr_invalid && csr_address == 12'h340)
            mscratch <= csr_writedata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                         input logic [31:0] v, input logic [4:0] rd);
        int n;
        req_funct3 = f3; req_address = a; req_rs1_index = r1; req_rs1_value = v; req_rd_index = rd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin step(); n++; end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL accept_wait: req_ready=%b required 1", req_ready); end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0;
        req_funct3 = 3'd0; req_address = 12'd0; req_rs1_index = 5'd0; req_rs1_value = 32'd0; req_rd_index = 5'd0;
        step(); step();
        rst = 1'b0; mem_clr = 1'b0;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        tests++; if (csr_cmd !== 4'd0) begin fails++; $display("FAIL reset_cmd: got %0d want 0", csr_cmd); end
        tests++; if ({resp_valid, resp_illegal, resp_rd_write} !== 3'b000) begin fails++; $display("FAIL reset_resp: got %b want 000", {resp_valid, resp_illegal, resp_rd_write}); end
        tests++; if (resp_rd_index !== 5'd0 || resp_rd_data !== 32'd0) begin fails++; $display("FAIL reset_rd: idx=%0d data=%h want 0/0", resp_rd_index, resp_rd_data); end
        tests++; if (csr_writedata !== 32'd0 || csr_address !== 12'd0) begin fails++; $display("FAIL reset_csr: wd=%h addr=%h want 0/0", csr_writedata, csr_address); end
    endtask

    task automatic test_csrrw();
        drive(3'b001, 12'h340, 5'd1, 32'h12345678, 5'd5);
        tests++; if (csr_cmd !== 4'd3 || csr_writedata !== 32'h12345678) begin fails++; $display("FAIL rw_issue: cmd=%0d wd=%h want 3/12345678", csr_cmd, csr_writedata); end
        tests++; if (req_ready !== 1'b0 || csr_address !== 12'h340) begin fails++; $display("FAIL rw_busy: ready=%b addr=%h want 0/340", req_ready, csr_address); end
        step();
        tests++; if ({resp_valid, resp_illegal, resp_rd_write} !== 3'b101) begin fails++; $display("FAIL rw_resp: got %b want 101", {resp_valid, resp_illegal, resp_rd_write}); end
        tests++; if (resp_rd_data !== 32'd0 || resp_rd_index !== 5'd5 || csr_cmd !== 4'd0) begin fails++; $display("FAIL rw_data: data=%h idx=%0d cmd=%0d want 0/5/0", resp_rd_data, resp_rd_index, csr_cmd); end
        tests++; if (mscratch !== 32'h12345678) begin fails++; $display("FAIL rw_mem: got %h want 12345678", mscratch); end
        step();
    endtask

    task automatic test_rmw_set();
        drive(3'b010, 12'h340, 5'd2, 32'h000000F0, 5'd6);
        tests++; if (csr_cmd !== 4'd2 || csr_writedata !== 32'd0) begin fails++; $display("FAIL rs_read: cmd=%0d wd=%h want 2/0", csr_cmd, csr_writedata); end
        step();
        tests++; if (csr_cmd !== 4'd1 || csr_writedata !== 32'h123456F8) begin fails++; $display("FAIL rs_write: cmd=%0d wd=%h want 1/123456F8", csr_cmd, csr_writedata); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rs_early: resp_valid=%b want 0", resp_valid); end
        step();
        tests++; if ({resp_valid, resp_illegal, resp_rd_write} !== 3'b101 || resp_rd_data !== 32'h12345678) begin fails++; $display("FAIL rs_resp: flags=%b data=%h want 101/12345678", {resp_valid, resp_illegal, resp_rd_write}, resp_rd_data); end
        tests++; if (mscratch !== 32'h123456F8) begin fails++; $display("FAIL rs_mem: got %h want 123456F8", mscratch); end
        step();
    endtask

    task automatic test_rmw_clear_imm();
        drive(3'b111, 12'h340, 5'd8, 32'hFFFFFFFF, 5'd0);
        tests++; if (csr_cmd !== 4'd2) begin fails++; $display("FAIL rci_read: cmd=%0d want 2", csr_cmd); end
        step();
        tests++; if (csr_cmd !== 4'd1 || csr_writedata !== 32'h123456F0) begin fails++; $display("FAIL rci_write: cmd=%0d wd=%h want 1/123456F0", csr_cmd, csr_writedata); end
        step();
        tests++; if ({resp_valid, resp_illegal, resp_rd_write} !== 3'b100) begin fails++; $display("FAIL rci_resp: got %b want 100", {resp_valid, resp_illegal, resp_rd_write}); end
        step();
        drive(3'b110, 12'hF11, 5'd0, 32'hFFFFFFFF, 5'd7);
        tests++; if (csr_cmd !== 4'd2) begin fails++; $display("FAIL rsi0_read: cmd=%0d want 2", csr_cmd); end
        step();
        tests++; if (csr_cmd !== 4'd0 || resp_valid !== 1'b1) begin fails++; $display("FAIL rsi0_nowrite: cmd=%0d valid=%b want 0/1", csr_cmd, resp_valid); end
        tests++; if (resp_rd_data !== 32'h0A1AA1E0 || resp_rd_write !== 1'b1 || resp_illegal !== 1'b0) begin fails++; $display("FAIL rsi0_resp: data=%h wr=%b ill=%b want 0A1AA1E0/1/0", resp_rd_data, resp_rd_write, resp_illegal); end
        step();
    endtask

    task automatic test_illegal();
        drive(3'b001, 12'hF11, 5'd1, 32'h5, 5'd3);
        tests++; if (csr_cmd !== 4'd3) begin fails++; $display("FAIL ill_rw_issue: cmd=%0d want 3", csr_cmd); end
        step();
        tests++; if ({resp_valid, resp_illegal, resp_rd_write} !== 3'b110 || resp_rd_data !== 32'd0) begin fails++; $display("FAIL ill_rw_resp: flags=%b data=%h want 110/0", {resp_valid, resp_illegal, resp_rd_write}, resp_rd_data); end
        step();
        drive(3'b110, 12'hF11, 5'd1, 32'd0, 5'd4);
        tests++; if (csr_cmd !== 4'd2) begin fails++; $display("FAIL ill_rsi_read: cmd=%0d want 2", csr_cmd); end
        step();
        tests++; if (csr_cmd !== 4'd1 || csr_writedata !== 32'h0A1AA1E1) begin fails++; $display("FAIL ill_rsi_write: cmd=%0d wd=%h want 1/0A1AA1E1", csr_cmd, csr_writedata); end
        step();
        tests++; if ({resp_valid, resp_illegal, resp_rd_write} !== 3'b110) begin fails++; $display("FAIL ill_rsi_resp: got %b want 110", {resp_valid, resp_illegal, resp_rd_write}); end
        step();
        tests++; if (resp_illegal !== 1'b1 || resp_rd_index !== 5'd4 || resp_valid !== 1'b0) begin fails++; $display("FAIL ill_hold: ill=%b idx=%0d valid=%b want 1/4/0", resp_illegal, resp_rd_index, resp_valid); end
        tests++; if (mscratch !== 32'h123456F0) begin fails++; $display("FAIL ill_mem: got %h want 123456F0", mscratch); end
    endtask

    task automatic test_bad_funct3();
        req_funct3 = 3'b100; req_address = 12'h340; req_rs1_index = 5'd1; req_rs1_value = 32'h1; req_rd_index = 5'd9;
        req_valid = 1'b1;
        tests++; if (req_ready !== 1'b1 || csr_cmd !== 4'd0) begin fails++; $display("FAIL bad_accept: ready=%b cmd=%0d want 1/0", req_ready, csr_cmd); end
        step();
        req_valid = 1'b0;
        tests++; if ({resp_valid, resp_illegal, resp_rd_write} !== 3'b110 || csr_cmd !== 4'd0) begin fails++; $display("FAIL bad_resp: flags=%b cmd=%0d want 110/0", {resp_valid, resp_illegal, resp_rd_write}, csr_cmd); end
        tests++; if (resp_rd_data !== 32'd0 || resp_rd_index !== 5'd9) begin fails++; $display("FAIL bad_rd: data=%h idx=%0d want 0/9", resp_rd_data, resp_rd_index); end
        step();
        tests++; if (csr_cmd !== 4'd0 || req_ready !== 1'b1) begin fails++; $display("FAIL bad_after: cmd=%0d ready=%b want 0/1", csr_cmd, req_ready); end
    endtask

    task automatic test_back_to_back();
        req_funct3 = 3'b001; req_address = 12'h340; req_rs1_index = 5'd1; req_rs1_value = 32'hAAAA0000; req_rd_index = 5'd5;
        req_valid = 1'b1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_first_ready: got %b want 1", req_ready); end
        step();
        req_funct3 = 3'b010; req_rs1_index = 5'd3; req_rs1_value = 32'h1; req_rd_index = 5'd2;
        tests++; if (req_ready !== 1'b0 || csr_cmd !== 4'd3 || csr_writedata !== 32'hAAAA0000) begin fails++; $display("FAIL b2b_issue_a: ready=%b cmd=%0d wd=%h want 0/3/AAAA0000", req_ready, csr_cmd, csr_writedata); end
        step();
        tests++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rd_data !== 32'h123456F0 || resp_rd_index !== 5'd5) begin fails++; $display("FAIL b2b_resp_a: ready=%b valid=%b data=%h idx=%0d want 0/1/123456F0/5", req_ready, resp_valid, resp_rd_data, resp_rd_index); end
        step();
        tests++; if (req_ready !== 1'b1 || csr_cmd !== 4'd0) begin fails++; $display("FAIL b2b_idle: ready=%b cmd=%0d want 1/0", req_ready, csr_cmd); end
        step();
        req_valid = 1'b0;
        tests++; if (csr_cmd !== 4'd2 || req_ready !== 1'b0) begin fails++; $display("FAIL b2b_issue_b: cmd=%0d ready=%b want 2/0", csr_cmd, req_ready); end
        step();
        tests++; if (csr_cmd !== 4'd1 || csr_writedata !== 32'hAAAA0001) begin fails++; $display("FAIL b2b_write_b: cmd=%0d wd=%h want 1/AAAA0001", csr_cmd, csr_writedata); end
        step();
        tests++; if (resp_valid !== 1'b1 || resp_rd_data !== 32'hAAAA0000 || resp_rd_index !== 5'd2 || resp_rd_write !== 1'b1) begin fails++; $display("FAIL b2b_resp_b: valid=%b data=%h idx=%0d wr=%b want 1/AAAA0000/2/1", resp_valid, resp_rd_data, resp_rd_index, resp_rd_write); end
        step();
    endtask

    task automatic test_reset_mid();
        drive(3'b010, 12'h340, 5'd4, 32'h000000FF, 5'd1);
        tests++; if (csr_cmd !== 4'd2) begin fails++; $display("FAIL rst_mid_read: cmd=%0d want 2", csr_cmd); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (csr_cmd !== 4'd0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_abort: cmd=%0d ready=%b valid=%b want 0/1/0", csr_cmd, req_ready, resp_valid); end
        step();
        tests++; if (csr_cmd !== 4'd0 || resp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_quiet: cmd=%0d valid=%b want 0/0", csr_cmd, resp_valid); end
        step();
        tests++; if (mscratch !== 32'hAAAA0001) begin fails++; $display("FAIL rst_mid_mem: got %h want AAAA0001", mscratch); end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_rmw_set();
        test_rmw_clear_imm();
        test_illegal();
        test_bad_funct3();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/armleocpu_csr_requester.md
Name: armleocpu_csr_requester

Overview:
- Execute-stage initiator for the CPU's CSR command interface: takes one decoded Zicsr instruction per handshake and drives csr_cmd/csr_address/csr_writedata into the CSR register file.
- Implements CSRRS/CSRRC and their immediate forms as a READ cycle followed by a WRITE cycle. The CSR file itself implements only WRITE, READ and READ_WRITE.
- Returns the old CSR value for rd, or flags an illegal instruction from csr_invalid or a bad funct3.

Parameters:
CMD_WIDTH, 4, width of csr_cmd; encodings NONE=0, WRITE=1, READ=2, READ_WRITE=3 (other codes never driven)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  instruction offered
req_ready  out  1  block accepts request (high only in IDLE)
req_funct3  in  3  Zicsr funct3
req_address  in  12  CSR address (instr[31:20])
req_rs1_index  in  5  rs1 field / zimm
req_rs1_value  in  32  rs1 register value
req_rd_index  in  5  destination register
csr_cmd  out  CMD_WIDTH  command to CSR file
csr_address  out  12  CSR address
csr_writedata  out  32  write value
csr_readdata  in  32  combinational read value from CSR file
csr_invalid  in  1  combinational access fault from CSR file
resp_valid  out  1  one-cycle completion pulse
resp_illegal  out  1  illegal instruction (valid with resp_valid)
resp_rd_write  out  1  write rd this cycle
resp_rd_index  out  5  rd index
resp_rd_data  out  32  old CSR value

Behaviour:
- Request capture:
  - The request is accepted on a cycle where req_valid && req_ready.
  - funct3, address, rd, rs1 index and operand are latched.
  - Operand = rs1_value when funct3[2]=0, else zero-extended zimm (rs1_index).
  - mask_zero = (operand source is x0 / zimm==0).
- States: IDLE, ISSUE, RMW_WRITE, RESP.
- IDLE:
  - req_ready=1 and csr_cmd=NONE.
  - On accept, funct3[1:0]==00 (funct3 000 or 100) → RESP with illegal=1 and no CSR command ever driven.
  - Any other accept → ISSUE.
- ISSUE (exactly one cycle, one command):
  - RW/RWI with rd==0 → WRITE, writedata=operand.
  - RW/RWI with rd!=0 → READ_WRITE, writedata=operand.
  - RS/RC/RSI/RCI → READ, writedata=0.
  - csr_invalid is sampled in the same cycle.
  - If invalid → RESP, illegal=1.
  - Else old value = csr_readdata is captured.
  - Next state: RS/RC with mask_zero → RESP; RS/RC otherwise → RMW_WRITE; RW → RESP.
- RMW_WRITE (one cycle):
  - csr_cmd=WRITE.
  - writedata = old|operand for set forms, old&~operand for clear forms.
  - csr_invalid here (read-only address) → illegal=1. The CSR file does not update on an invalid write, so no partial side effect occurs.
  - → RESP.
- RESP (one cycle):
  - resp_valid=1 and csr_cmd=NONE; → IDLE.
  - resp_rd_write = !illegal && rd!=0.
  - resp_rd_data = captured old value (0 for WRITE-only and illegal cases).
  - resp_illegal, resp_rd_index, resp_rd_data are held stable until the next accept.
- csr_cmd is non-NONE for exactly one cycle per issued command and never for two consecutive identical commands. The CSR file commits on every edge with an active command.
- csr_address = latched address in all states.
- Latency from accept cycle T:
  - single-command op: resp at T+2;
  - RMW op: resp at T+3;
  - bad funct3: resp at T+1.
- Throughput: one instruction per 3 or 4 cycles. req_ready stays low outside IDLE; req_valid is ignored there.
- Reset (rst=1 at an edge):
  - state=IDLE.
  - Outputs: csr_cmd=NONE, resp_valid=0, resp_illegal=0, resp_rd_write=0, resp_rd_index=0, resp_rd_data=0, csr_writedata=0, csr_address=0.
  - Reset asserted mid-RMW (in ISSUE or RMW_WRITE) aborts the op. No WRITE is issued after the reset edge, and no response is produced.

Test Plan:
- mscratch(0x340)=0, CSRRW rd=5 rs1_value=0x12345678 → T+1 READ_WRITE with writedata 0x12345678; T+2 resp_valid, rd_write=1, rd_data=0; mscratch reads back 0x12345678.
- mscratch=0x12345678, CSRRS rd=6 rs1_value=0x000000F0 → T+1 READ, T+2 WRITE 0x123456F8, T+3 rd_data=0x12345678.
- mscratch=0x123456F8, CSRRCI zimm=0x08 rd=0 → READ then WRITE 0x123456F0, rd_write=0. Then CSRRSI zimm=0 on 0xF11 rd=7 → READ only, no WRITE cycle, rd_data=0x0A1AA1E0 at T+2.
- CSRRW to 0xF11 → csr_invalid in ISSUE, resp_illegal=1, rd_write=0. CSRRSI zimm=1 on 0xF11 → READ ok, WRITE invalid at T+2, resp_illegal=1 at T+3, rd_write=0.
- funct3=100 → no csr_cmd other than NONE, resp_valid with illegal=1 at T+1. Back-to-back req_valid during busy → req_ready=0 and the second request is accepted only in IDLE.
- rst asserted in ISSUE of a CSRRS → next cycle csr_cmd=NONE, req_ready=1, no resp_valid, mscratch unchanged.
